// File: rtl/layer_hidden_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_hidden_mac_sequencer
// Description : Issues one MAC request per input element for a hidden neuron,
//               waits for the accumulate-complete ack, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_hidden_mac_sequencer #(
    parameter int N_INPUTS = 4,
    parameter int ADDR_W   = 2,
    parameter int TIMEOUT  = 16,
    parameter int TO_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              first,
    output logic              last,
    input  logic              ack,
    input  logic              ack_mac,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_MAC = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(N_INPUTS - 1);
    localparam logic [TO_W-1:0]   c_to_last   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit                c_to_en     = (TIMEOUT > 0);

    state_t            r_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic [ADDR_W-1:0] w_addr_nxt;

    assign w_addr_nxt = addr + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
            req      <= 1'b0;
            addr     <= '0;
            first    <= 1'b0;
            last     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        req     <= 1'b1;
                        addr    <= '0;
                        first   <= 1'b1;
                        last    <= (c_last_addr == '0);
                        busy    <= 1'b1;
                        err     <= 1'b0;
                    end
                    if (ack) begin
                        err <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // A premature ack_mac only flags; a concurrent ack is still honoured
                    // because the MAC has already consumed the operand.
                    if (ack_mac) begin
                        err <= 1'b1;
                    end
                    if (ack) begin
                        if (last) begin
                            r_state  <= S_WAIT_MAC;
                            req      <= 1'b0;
                            first    <= 1'b0;
                            last     <= 1'b0;
                            addr     <= '0;
                            r_to_cnt <= '0;
                        end else begin
                            addr  <= w_addr_nxt;
                            first <= 1'b0;
                            last  <= (w_addr_nxt == c_last_addr);
                        end
                    end
                end
                S_WAIT_MAC: begin
                    if (ack) begin
                        err <= 1'b1;
                    end
                    if (ack_mac) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else if (c_to_en && (r_to_cnt == c_to_last)) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else if (c_to_en) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        err <= 1'b1;
                    end
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    req     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_hidden_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_hidden_mac_sequencer
// Description : Directed vector bench for the hidden-layer MAC sequencer,
//               with a 4-input and a 1-input instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_hidden_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, ack = 1'b0, ack_mac = 1'b0;
    logic       req, first, last, busy, done, err;
    logic [1:0] addr;
    logic       start1 = 1'b0, ack1 = 1'b0, ack_mac1 = 1'b0;
    logic       req1, first1, last1, busy1, done1, err1;
    logic [0:0] addr1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    layer_hidden_mac_sequencer #(.N_INPUTS(4), .ADDR_W(2), .TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .req(req), .addr(addr), .first(first),
        .last(last), .ack(ack), .ack_mac(ack_mac), .busy(busy), .done(done), .err(err)
    );

    layer_hidden_mac_sequencer #(.N_INPUTS(1), .ADDR_W(1), .TIMEOUT(16), .TO_W(5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .req(req1), .addr(addr1), .first(first1),
        .last(last1), .ack(ack1), .ack_mac(ack_mac1), .busy(busy1), .done(done1), .err(err1)
    );

    typedef struct packed {
        logic       start;
        logic       ack;
        logic       ack_mac;
        logic       req;
        logic [1:0] addr;
        logic       first;
        logic       last;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic s, logic a, logic m, logic rq, logic [1:0] ad,
                               logic f, logic l, logic b, logic d, logic e);
        vec_t r;
        r = '{s, a, m, rq, ad, f, l, b, d, e};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are held for one clock; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic s, input logic a, input logic m);
        start = s; ack = a; ack_mac = m;
        @(posedge clk);
        #1;
        start = 1'b0; ack = 1'b0; ack_mac = 1'b0;
    endtask

    task automatic step1(input logic s, input logic a, input logic m);
        start1 = s; ack1 = a; ack_mac1 = m;
        @(posedge clk);
        #1;
        start1 = 1'b0; ack1 = 1'b0; ack_mac1 = 1'b0;
    endtask

    function automatic logic [7:0] outs();
        return {req, addr, first, last, busy, done, err};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs(), 8'h00);
        check("reset_outs_n1", {req1, addr1, first1, last1, busy1, done1, err1}, 7'h00);
        rst = 1'b1;
        step(0, 0, 0);
        check("idle_after_reset", outs(), 8'h00);

        // nominal pass, start while busy, start during done
        vecs.push_back(v(1,0,0, 1,2'd0,1,0,1,0,0));
        vecs.push_back(v(0,1,0, 1,2'd1,0,0,1,0,0));
        vecs.push_back(v(1,1,0, 1,2'd2,0,0,1,0,0));
        vecs.push_back(v(0,1,0, 1,2'd3,0,1,1,0,0));
        vecs.push_back(v(0,1,0, 0,2'd0,0,0,1,0,0));
        vecs.push_back(v(0,0,0, 0,2'd0,0,0,1,0,0));
        vecs.push_back(v(0,0,1, 0,2'd0,0,0,1,1,0));
        vecs.push_back(v(1,0,0, 0,2'd0,0,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,2'd0,0,0,0,0,0));
        // stalled acks: one ack every third cycle
        vecs.push_back(v(1,0,0, 1,2'd0,1,0,1,0,0));
        vecs.push_back(v(0,0,0, 1,2'd0,1,0,1,0,0));
        vecs.push_back(v(0,0,0, 1,2'd0,1,0,1,0,0));
        vecs.push_back(v(0,1,0, 1,2'd1,0,0,1,0,0));
        vecs.push_back(v(0,0,0, 1,2'd1,0,0,1,0,0));
        vecs.push_back(v(0,0,0, 1,2'd1,0,0,1,0,0));
        vecs.push_back(v(0,1,0, 1,2'd2,0,0,1,0,0));
        vecs.push_back(v(0,0,0, 1,2'd2,0,0,1,0,0));
        vecs.push_back(v(0,0,0, 1,2'd2,0,0,1,0,0));
        vecs.push_back(v(0,1,0, 1,2'd3,0,1,1,0,0));
        vecs.push_back(v(0,0,0, 1,2'd3,0,1,1,0,0));
        vecs.push_back(v(0,0,0, 1,2'd3,0,1,1,0,0));
        vecs.push_back(v(0,1,0, 0,2'd0,0,0,1,0,0));
        vecs.push_back(v(0,0,1, 0,2'd0,0,0,1,1,0));
        vecs.push_back(v(0,0,0, 0,2'd0,0,0,0,0,0));
        // premature ack_mac in ISSUE, spurious ack in WAIT_MAC and IDLE
        vecs.push_back(v(1,0,0, 1,2'd0,1,0,1,0,0));
        vecs.push_back(v(0,1,0, 1,2'd1,0,0,1,0,0));
        vecs.push_back(v(0,0,1, 1,2'd1,0,0,1,0,1));
        vecs.push_back(v(0,1,0, 1,2'd2,0,0,1,0,1));
        vecs.push_back(v(0,1,0, 1,2'd3,0,1,1,0,1));
        vecs.push_back(v(0,1,0, 0,2'd0,0,0,1,0,1));
        vecs.push_back(v(0,1,0, 0,2'd0,0,0,1,0,1));
        vecs.push_back(v(0,0,1, 0,2'd0,0,0,1,1,1));
        vecs.push_back(v(0,0,0, 0,2'd0,0,0,0,0,1));
        vecs.push_back(v(1,0,0, 1,2'd0,1,0,1,0,0));
        vecs.push_back(v(0,1,0, 1,2'd1,0,0,1,0,0));
        vecs.push_back(v(0,1,0, 1,2'd2,0,0,1,0,0));
        vecs.push_back(v(0,1,0, 1,2'd3,0,1,1,0,0));
        vecs.push_back(v(0,1,0, 0,2'd0,0,0,1,0,0));
        vecs.push_back(v(0,0,1, 0,2'd0,0,0,1,1,0));
        vecs.push_back(v(0,0,0, 0,2'd0,0,0,0,0,0));
        vecs.push_back(v(0,1,0, 0,2'd0,0,0,0,0,1));
        vecs.push_back(v(0,0,0, 0,2'd0,0,0,0,0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].ack, vecs[i].ack_mac);
            check($sformatf("vec%0d {req,addr,first,last,busy,done,err}", i), outs(),
                  {vecs[i].req, vecs[i].addr, vecs[i].first, vecs[i].last,
                   vecs[i].busy, vecs[i].done, vecs[i].err});
        end

        // timeout: 16 cycles in WAIT_MAC, then abort with err and no done
        step(1, 0, 0);
        check("timeout_start_clears_err", {req, err}, 2'b10);
        repeat (4) step(0, 1, 0);
        check("timeout_enter_wait", {req, busy, err}, 3'b010);
        saw_done = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 0);
            if (done) saw_done = 1'b1;
            if (k < 16) check($sformatf("timeout_wait%0d {busy,err}", k), {busy, err}, 2'b10);
        end
        check("timeout_abort {busy,err,done}", {busy, err, done}, 3'b010);
        check("timeout_no_done", saw_done, 1'b0);
        step(1, 0, 0);
        check("after_timeout_start", outs(), {1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        repeat (4) step(0, 1, 0);
        step(0, 0, 1);
        check("after_timeout_done", {done, err}, 2'b10);
        step(0, 0, 0);
        check("after_timeout_idle", outs(), 8'h00);

        // asynchronous reset mid-pass
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        check("midpass_addr", {req, addr}, {1'b1, 2'd2});
        #2 rst = 1'b0;
        #1;
        check("async_reset_outs", outs(), 8'h00);
        #2 rst = 1'b1;
        repeat (3) step(0, 0, 0);
        check("idle_after_release", outs(), 8'h00);

        // single-input instance
        step1(1, 0, 0);
        check("n1_req", {req1, addr1, first1, last1, busy1}, 5'b1_0_1_1_1);
        step1(0, 1, 0);
        check("n1_wait", {req1, busy1, done1}, 3'b010);
        step1(0, 0, 1);
        check("n1_done", {req1, busy1, done1, err1}, 4'b0110);
        step1(0, 0, 0);
        check("n1_idle", {req1, busy1, done1, err1}, 4'b0000);
        step1(0, 0, 0);
        check("n1_no_extra_req", {req1, busy1}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
